// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared definitions for the FIFO read-port arbiter. It holds the
//            arbiter state encoding and the default burst and start-threshold
//            parameter values.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  localparam int DEF_BURST_MAX = 4;
  localparam int DEF_MIN_WORDS = 1;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. It selects the first set
//            request bit at or after rr_ptr and wraps around to bit 0.
// Ports    : req    - request vector
//            rr_ptr - index with highest priority
//            grant  - one-hot selected requester (0 if none)
//            owner  - index of the selected requester
//            valid  - at least one request is set
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   owner,
  output logic               valid
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    grant = '0;
    owner = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Walk the request bits starting at rr_ptr. The first hit wins.
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        owner       = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_rd_arbiter.sv
// ============================================================================
// Module   : fifo_rd_arbiter
// Purpose  : Shares a FIFO read port among NUM_REQ consumers. Arbitration is
//            round-robin, and each grant gives a burst of up to BURST_MAX
//            reads. The returned data is tagged with a one-hot destination.
// Ports    : clk, rst_n             - clock, async active-low reset
//            req                    - per-consumer read requests (level)
//            fifo_empty/full/words  - FIFO status
//            fifo_data              - FIFO data_out (valid 1 cycle after rd_en)
//            rd_en                  - FIFO read enable
//            gnt                    - one-hot current owner, 0 when idle
//            busy                   - high in BURST or DRAIN
//            out_valid/data/dst     - returned word and its destination
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 4,
  parameter int BURST_MAX = DEF_BURST_MAX,
  parameter int MIN_WORDS = DEF_MIN_WORDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               fifo_empty,
  input  logic               fifo_full,
  input  logic [CNT_W-1:0]   fifo_words,
  input  logic [DATA_W-1:0]  fifo_data,
  output logic               rd_en,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [NUM_REQ-1:0] out_dst
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = $clog2(BURST_MAX + 1);
  localparam logic [BEAT_W-1:0] BEAT_LIM  = BEAT_W'(BURST_MAX);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               rd_en_c;
  logic               valid_q;
  logic [NUM_REQ-1:0] dst_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_owner;
  logic               pick_valid;
  logic               start_ok;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_gnt),
    .owner  (pick_owner),
    .valid  (pick_valid)
  );

  // A full FIFO also qualifies a start, so a threshold larger than the counter
  // can represent still lets a grant start.
  assign start_ok = ((fifo_words >= CNT_W'(MIN_WORDS)) || fifo_full) && pick_valid;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    rd_en_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          gnt_d   = pick_gnt;
          owner_d = pick_owner;
          beat_d  = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        // When the owner drops req or the FIFO is empty, reading stops in the
        // same cycle. This also guarantees that no read hits an empty FIFO.
        rd_en_c = req[owner_q] & ~fifo_empty & (beat_q < BEAT_LIM);
        if (rd_en_c) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_LAST) begin
            state_d = ST_DRAIN;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last beat returns during this cycle. gnt stays valid for it.
        state_d  = ST_IDLE;
        gnt_d    = '0;
        rr_ptr_d = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
      dst_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      valid_q  <= rd_en_c;
      dst_q    <= rd_en_c ? gnt_q : '0;
    end
  end

  assign rd_en     = rd_en_c;
  assign gnt       = gnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = valid_q;
  assign out_data  = fifo_data;
  assign out_dst   = dst_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
// ============================================================================
// Module   : tb_fifo_rd_arbiter
// Purpose  : Self-checking bench for fifo_rd_arbiter, driven by a small
//            behavioural FIFO model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       fifo_empty, fifo_full;
  logic [3:0] fifo_words;
  logic [7:0] fifo_data = 8'h00;
  logic       rd_en, busy, out_valid;
  logic [3:0] gnt, out_dst;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  fifo_rd_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .CNT_W(4), .BURST_MAX(4), .MIN_WORDS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_words(fifo_words), .fifo_data(fifo_data),
    .rd_en(rd_en), .gnt(gnt), .busy(busy),
    .out_valid(out_valid), .out_data(out_data), .out_dst(out_dst)
  );

  // FIFO model: pushes come from the stimulus, pops come from rd_en.
  logic [7:0] mem [0:31];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic flush = 1'b0;
  int   fcnt;
  assign fcnt       = wr_ptr - rd_ptr;
  assign fifo_empty = (fcnt == 0);
  assign fifo_full  = (fcnt >= 16);
  assign fifo_words = 4'(fcnt);

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (rd_en && fcnt > 0) begin
      fifo_data <= mem[rd_ptr % 32];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 32] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor logs, sampled on the falling edge.
  int g_log[$];
  int d_log[$];
  int t_log[$];
  int gap_log[$];
  int rd_total, empty_viol, since_rd;
  bit seen_rd;
  logic [3:0] prev_gnt;

  task automatic clear_logs();
    g_log.delete(); d_log.delete(); t_log.delete(); gap_log.delete();
    rd_total = 0; empty_viol = 0; since_rd = 0; seen_rd = 0; prev_gnt = 4'b0;
  endtask

  task automatic run_mon(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (gnt != 4'b0 && prev_gnt == 4'b0) g_log.push_back(int'(gnt));
      prev_gnt = gnt;
      if (out_valid) begin
        d_log.push_back(int'(out_data));
        t_log.push_back(int'(out_dst));
      end
      if (rd_en) begin
        rd_total++;
        if (fifo_empty) empty_viol++;
        if (seen_rd && since_rd > 0) gap_log.push_back(since_rd);
        seen_rd  = 1;
        since_rd = 0;
      end else begin
        since_rd++;
      end
    end
  endtask

  // Called at posedge+1. It leaves rst_n released and the FIFO empty.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       rd_en;
    logic [3:0] gnt;
    logic       busy;
    logic       ov;
    logic [7:0] data;
    logic [3:0] dst;
  } vec_t;

  vec_t vt [12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dropped;
    // Single consumer: 6 words, then a 4-beat burst, a re-grant and 2 beats.
    vt[0]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    vt[1]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0000};
    vt[2]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h01, 4'b0001};
    vt[3]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h02, 4'b0001};
    vt[4]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h03, 4'b0001};
    vt[5]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 8'h04, 4'b0001};
    vt[6]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    vt[7]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0000};
    vt[8]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h05, 4'b0001};
    vt[9]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 8'h06, 4'b0001};
    vt[10] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0000};
    vt[11] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};

    // Reset held with requests pending and 8 words available.
    #1 rst_n = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("reset_outs_c%0d", i), int'({rd_en, gnt, busy, out_valid, out_dst}), 0);
    end
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 6; i++) push(8'h01 + 8'(i));
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      req = vt[i].req;
      @(negedge clk);
      chk($sformatf("vec%0d_rd_en", i), int'(rd_en), int'(vt[i].rd_en));
      chk($sformatf("vec%0d_gnt", i), int'(gnt), int'(vt[i].gnt));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].busy));
      chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vt[i].ov));
      chk($sformatf("vec%0d_out_dst", i), int'(out_dst), int'(vt[i].dst));
      if (vt[i].ov) chk($sformatf("vec%0d_out_data", i), int'(out_data), int'(vt[i].data));
    end

    // Round-robin among requesters 0, 1 and 3 with 12 words.
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 12; i++) push(8'h30 + 8'(i));
    clear_logs();
    req = 4'b1011;
    run_mon(50);
    req = 4'b0000;
    chk("rr_ngrants", g_log.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("rr_grant%0d", i), (i < g_log.size()) ? g_log[i] : -1, (i == 0) ? 1 : (i == 1) ? 2 : 8);
    chk("rr_ndata", d_log.size(), 12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("rr_data%0d", i), (i < d_log.size()) ? d_log[i] : -1, 8'h30 + i);
      chk($sformatf("rr_dst%0d", i), (i < t_log.size()) ? t_log[i] : -1, (i < 4) ? 1 : (i < 8) ? 2 : 8);
    end
    chk("rr_ngaps", gap_log.size(), 2);
    for (int i = 0; i < 2; i++)
      chk($sformatf("rr_gap%0d", i), (i < gap_log.size()) ? gap_log[i] : -1, 2);
    chk("rr_empty_viol", empty_viol, 0);

    // The owner drops req after its second read.
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    clear_logs();
    req = 4'b0010;
    dropped = 0;
    for (int c = 0; c < 20 && !dropped; c++) begin
      run_mon(1);
      if (rd_total == 2) begin
        @(posedge clk); #1;
        req = 4'b0000;
        dropped = 1;
      end
    end
    chk("drop_reached", int'(dropped), 1);
    run_mon(10);
    chk("drop_rd_total", rd_total, 2);
    chk("drop_ndata", d_log.size(), 2);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("drop_data%0d", i), (i < d_log.size()) ? d_log[i] : -1, 8'h40 + i);
      chk($sformatf("drop_dst%0d", i), (i < t_log.size()) ? t_log[i] : -1, 2);
    end
    chk("drop_remaining", fcnt, 6);

    // Empty FIFO: no grant, then exactly one word after a single write.
    @(posedge clk); #1;
    do_reset();
    clear_logs();
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      run_mon(1);
      chk($sformatf("empty_idle_c%0d", i), int'({gnt, rd_en}), 0);
    end
    @(posedge clk); #1;
    push(8'h5A);
    run_mon(10);
    req = 4'b0000;
    chk("empty_first_grant", (g_log.size() > 0) ? g_log[0] : -1, 1);
    chk("empty_rd_total", rd_total, 1);
    chk("empty_ndata", d_log.size(), 1);
    chk("empty_data", (d_log.size() > 0) ? d_log[0] : -1, 8'h5A);
    chk("empty_dst", (t_log.size() > 0) ? t_log[0] : -1, 1);
    chk("empty_viol", empty_viol, 0);

    // Reset during a burst owned by requester 2.
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
    clear_logs();
    req = 4'b0100;
    for (int c = 0; c < 20 && rd_total < 2; c++) run_mon(1);
    chk("midrst_reads_before", rd_total, 2);
    @(posedge clk); #1;
    chk("midrst_pre_gnt", int'(gnt), 4);
    chk("midrst_pre_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", int'({rd_en, gnt, busy, out_valid, out_dst}), 0);
    @(posedge clk); #1;
    req = 4'b0101;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_logs();
    run_mon(8);
    req = 4'b0000;
    chk("midrst_first_grant", (g_log.size() > 0) ? g_log[0] : -1, 1);
    chk("midrst_first_data", (d_log.size() > 0) ? d_log[0] : -1, 8'h62);
    chk("midrst_first_dst", (t_log.size() > 0) ? t_log[0] : -1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
